// File: rtl/snake_kb_pkg.sv
// Shared definitions for the snake-game keyboard front end.
// Holds the direction encodings, scan-code constants, the per-player key
// table, the receiver and decoder state enums, and the key lookup and
// reversal helper functions.
package snake_kb_pkg;

  localparam logic [4:0] DIR_NONE  = 5'b00000;
  localparam logic [4:0] DIR_UP    = 5'b00010;
  localparam logic [4:0] DIR_LEFT  = 5'b00100;
  localparam logic [4:0] DIR_DOWN  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;
  localparam logic [4:0] DIR_RESET = 5'b11111;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Key table entry: bit 8 = E0-extended, bits 7:0 = make code.
  // Rows are players 0..3, columns are up / left / down / right.
  localparam logic [8:0] KEY_MAP [4][4] = '{
    '{9'h175, 9'h16B, 9'h172, 9'h174},
    '{9'h01D, 9'h01C, 9'h01B, 9'h023},
    '{9'h043, 9'h03B, 9'h042, 9'h04B},
    '{9'h075, 9'h06B, 9'h072, 9'h074}
  };

  localparam logic [4:0] KEY_DIR [4] = '{DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT};

  typedef enum logic [1:0] {D_IDLE, D_EXT, D_BRK, D_EXT_BRK} dec_state_t;
  typedef enum logic {IDLE, SHIFT} rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] player;
    logic [4:0] dir;
  } key_hit_t;

  function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] code);
    key_hit_t r;
    r = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (KEY_MAP[p][k] == {ext, code}) begin
          r.hit    = 1'b1;
          r.player = 2'(p);
          r.dir    = KEY_DIR[k];
        end
      end
    end
    return r;
  endfunction

  // True only for a strict UP/DOWN or LEFT/RIGHT reversal; NONE and RESET
  // match neither side so they never block.
  function automatic logic dir_opposite(input logic [4:0] cur, input logic [4:0] req);
    return ((cur == DIR_UP)    && (req == DIR_DOWN))  ||
           ((cur == DIR_DOWN)  && (req == DIR_UP))    ||
           ((cur == DIR_LEFT)  && (req == DIR_RIGHT)) ||
           ((cur == DIR_RIGHT) && (req == DIR_LEFT));
  endfunction

endpackage

// File: rtl/ps2_multi_dir_decoder_if.sv
// Pin/bus bundle for ps2_multi_dir_decoder.
//   ps2_clk, ps2_data : raw PS/2 pins (driven by the keyboard side)
//   direction         : 5 bits per player, player p at [5p+4:5p]
//   dir_valid         : per-player write pulse
//   reset_req         : pulse on Enter make
//   frame_err         : pulse on framing/parity error or timeout
// Modports: master = keyboard/consumer side, slave = decoder.
interface ps2_multi_dir_decoder_if #(
  parameter int unsigned NUM_PLAYERS = 2
);
  import snake_kb_pkg::*;

  logic                     ps2_clk;
  logic                     ps2_data;
  logic [5*NUM_PLAYERS-1:0] direction;
  logic [NUM_PLAYERS-1:0]   dir_valid;
  logic                     reset_req;
  logic                     frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  direction, dir_valid, reset_req, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output direction, dir_valid, reset_req, frame_err
  );
endinterface

// File: rtl/ps2_multi_dir_decoder_rx.sv
// PS/2 frame receiver.
// Synchronises both pins, debounces ps2_clk (FILTER_LEN equal samples),
// samples data on each filtered falling edge, checks start/stop/odd parity
// and aborts a stalled frame after TIMEOUT_CYCLES clocks without a strobe.
//   clk, reset            : system clock, synchronous active-high reset
//   ps2_clk_i, ps2_data_i : raw asynchronous pins
//   rx_byte_o, rx_valid_o : accepted byte with 1-cycle valid
//   frame_err_o           : 1-cycle pulse on rejected or timed-out frame
module ps2_rx
  import snake_kb_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       frame_err_o
);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_flt_q;
  logic [FW-1:0] flt_cnt_q;
  rx_state_t     state_q;
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shift_q;
  logic [TW-1:0] to_cnt_q;
  logic [7:0]    rx_byte_q;
  logic          rx_valid_q, frame_err_q;

  logic          flt_flip, strobe, frame_ok;
  logic [10:0]   frame;

  assign flt_flip = (clk_sync_q[1] != clk_flt_q) && (flt_cnt_q == FW'(FILTER_LEN - 1));
  assign strobe   = flt_flip && clk_flt_q;
  // The stop bit is the live sample; the other ten bits are already shifted in.
  assign frame    = {data_sync_q[1], shift_q};
  assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_flt_q   <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (clk_sync_q[1] == clk_flt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_flip) begin
        clk_flt_q <= clk_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (strobe) begin
            shift_q   <= {data_sync_q[1], shift_q[9:1]};
            bit_cnt_q <= 4'd1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (strobe) begin
            to_cnt_q <= '0;
            if (bit_cnt_q == 4'd10) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
              if (frame_ok) begin
                rx_byte_q  <= frame[8:1];
                rx_valid_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              shift_q   <= {data_sync_q[1], shift_q[9:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            frame_err_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_byte_o   = rx_byte_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: rtl/ps2_multi_dir_decoder.sv
// Multi-player PS/2 direction decoder (top level).
// Feeds ps2_rx bytes through a prefix FSM (E0 / F0) and maps make codes to
// per-player 5-bit direction registers; Enter writes RESET to all players.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : ps2_multi_dir_decoder_if.slave (pins in, direction,
//                dir_valid, reset_req, frame_err out)
// Optional build macro REVERSAL_BLOCK_EN: drop makes that request the
// direction opposite to a player's current one.
module ps2_multi_dir_decoder
  import snake_kb_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 2,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_multi_dir_decoder_if.slave  bus
);
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (bus.ps2_clk),
    .ps2_data_i  (bus.ps2_data),
    .rx_byte_o   (rx_byte),
    .rx_valid_o  (rx_valid),
    .frame_err_o (rx_err)
  );

  dec_state_t               state_q;
  logic [5*NUM_PLAYERS-1:0] dir_q;
  logic [NUM_PLAYERS-1:0]   dir_valid_q;
  logic                     reset_req_q;

  logic                     make_valid, make_ext, is_enter;
  key_hit_t                 hit;
  logic [NUM_PLAYERS-1:0]   rev_block;

  always_comb begin
    make_valid = 1'b0;
    make_ext   = 1'b0;
    if (rx_valid) begin
      case (state_q)
        D_IDLE: make_valid = (rx_byte != SC_EXT) && (rx_byte != SC_BRK);
        D_EXT: begin
          make_valid = (rx_byte != SC_BRK);
          make_ext   = 1'b1;
        end
        default: make_valid = 1'b0;
      endcase
    end
    hit      = key_lookup(make_ext, rx_byte);
    is_enter = make_valid && !make_ext && (rx_byte == SC_ENTER);
  end

`ifdef REVERSAL_BLOCK_EN
  always_comb begin
    rev_block = '0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      rev_block[p] = dir_opposite(dir_q[5*p +: 5], hit.dir);
    end
  end
`else
  assign rev_block = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= D_IDLE;
      dir_q       <= '0;
      dir_valid_q <= '0;
      reset_req_q <= 1'b0;
    end else begin
      dir_valid_q <= '0;
      reset_req_q <= 1'b0;

      if (rx_err) begin
        state_q <= D_IDLE;
      end else if (rx_valid) begin
        case (state_q)
          D_IDLE: begin
            if (rx_byte == SC_EXT)      state_q <= D_EXT;
            else if (rx_byte == SC_BRK) state_q <= D_BRK;
          end
          D_EXT:   state_q <= (rx_byte == SC_BRK) ? D_EXT_BRK : D_IDLE;
          default: state_q <= D_IDLE;
        endcase
      end

      if (is_enter) begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
          dir_q[5*p +: 5] <= DIR_RESET;
        end
        dir_valid_q <= '1;
        reset_req_q <= 1'b1;
      end else if (make_valid && hit.hit) begin
        // Players beyond NUM_PLAYERS simply find no matching slot here.
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
          if ((hit.player == 2'(p)) && !rev_block[p]) begin
            dir_q[5*p +: 5] <= hit.dir;
            dir_valid_q[p]  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.direction = dir_q;
  assign bus.dir_valid = dir_valid_q;
  assign bus.reset_req = reset_req_q;
  assign bus.frame_err = rx_err;
endmodule

// File: tb/tb_ps2_multi_dir_decoder.sv
// Directed bench: a 2-player and a 1-player decoder share the same PS/2 pins.
module tb_ps2_multi_dir_decoder;
  localparam int unsigned FL = 4;
  localparam int unsigned TO = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  always #5 clk = ~clk;

  ps2_multi_dir_decoder_if #(.NUM_PLAYERS(2)) bus_a ();
  ps2_multi_dir_decoder_if #(.NUM_PLAYERS(1)) bus_b ();

  assign bus_a.ps2_clk  = ps2c;
  assign bus_a.ps2_data = ps2d;
  assign bus_b.ps2_clk  = ps2c;
  assign bus_b.ps2_data = ps2d;

  ps2_multi_dir_decoder #(.NUM_PLAYERS(2), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  ps2_multi_dir_decoder #(.NUM_PLAYERS(1), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  // Pulse-width counters: a stuck-high output counts once per cycle.
  int dv_a0 = 0, dv_a1 = 0, dv_b0 = 0, rr_a = 0, rr_b = 0, fe_a = 0, fe_b = 0;
  logic [1:0] dv_a_last = '0;
  always @(negedge clk) begin
    if (bus_a.dir_valid[0]) dv_a0 <= dv_a0 + 1;
    if (bus_a.dir_valid[1]) dv_a1 <= dv_a1 + 1;
    if (bus_b.dir_valid[0]) dv_b0 <= dv_b0 + 1;
    if (bus_a.reset_req)    rr_a  <= rr_a + 1;
    if (bus_b.reset_req)    rr_b  <= rr_b + 1;
    if (bus_a.frame_err)    fe_a  <= fe_a + 1;
    if (bus_b.frame_err)    fe_b  <= fe_b + 1;
    if (bus_a.dir_valid != 2'b00) dv_a_last <= bus_a.dir_valid;
  end

  int b_a0, b_a1, b_b0, b_rra, b_rrb, b_fea, b_feb;
  int checks = 0;
  int failures = 0;

  task automatic snap();
    b_a0 = dv_a0; b_a1 = dv_a1; b_b0 = dv_b0;
    b_rra = rr_a; b_rrb = rr_b; b_fea = fe_a; b_feb = fe_b;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2d = b;
    cyc(10);
    ps2c = 1'b0;
    cyc(20);
    ps2c = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic flip_par);
    logic par;
    par = ~(^data) ^ flip_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    send_bit(1'b1);
    cyc(20);
  endtask

  initial begin
    cyc(5);
    chk("rst_dir_a", 32'(bus_a.direction), 32'h0);
    chk("rst_dir_b", 32'(bus_b.direction), 32'h0);
    chk("rst_dv_a", 32'(bus_a.dir_valid), 32'h0);
    chk("rst_rr_a", 32'(bus_a.reset_req), 32'h0);
    chk("rst_fe_a", 32'(bus_a.frame_err), 32'h0);
    reset = 1'b0;
    cyc(5);

    // Arrow up -> player 0
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    chk("up_p0", 32'(bus_a.direction[4:0]), 32'(5'b00010));
    chk("up_p1", 32'(bus_a.direction[9:5]), 32'h0);
    chk("up_dv0", 32'(dv_a0 - b_a0), 32'd1);
    chk("up_dv1", 32'(dv_a1 - b_a1), 32'd0);
    chk("up_b_p0", 32'(bus_b.direction), 32'(5'b00010));

    // A (1C) -> player 1 LEFT; the 1-player DUT ignores it
    snap();
    send_frame(8'h1C, 1'b0);
    chk("a_p1", 32'(bus_a.direction[9:5]), 32'(5'b00100));
    chk("a_dv1", 32'(dv_a1 - b_a1), 32'd1);
    chk("a_b_dir", 32'(bus_b.direction), 32'(5'b00010));
    chk("a_b_dv", 32'(dv_b0 - b_b0), 32'd0);

    // Break F0 1C: no effect
    snap();
    send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    chk("brk_dv0", 32'(dv_a0 - b_a0), 32'd0);
    chk("brk_dv1", 32'(dv_a1 - b_a1), 32'd0);
    chk("brk_p1", 32'(bus_a.direction[9:5]), 32'(5'b00100));

    // Bad parity, then good 1D
    snap();
    send_frame(8'h1D, 1'b1);
    chk("par_fe", 32'(fe_a - b_fea), 32'd1);
    chk("par_fe_b", 32'(fe_b - b_feb), 32'd1);
    chk("par_dir", 32'(bus_a.direction), 32'({5'b00100, 5'b00010}));
    chk("par_dv1", 32'(dv_a1 - b_a1), 32'd0);
    send_frame(8'h1D, 1'b0);
    chk("w_p1", 32'(bus_a.direction[9:5]), 32'(5'b00010));
    chk("w_fe", 32'(fe_a - b_fea), 32'd1);

    // Enter
    snap();
    send_frame(8'h5A, 1'b0);
    chk("ent_dir_a", 32'(bus_a.direction), 32'h3FF);
    chk("ent_dv_pat", 32'(dv_a_last), 32'(2'b11));
    chk("ent_dv0", 32'(dv_a0 - b_a0), 32'd1);
    chk("ent_dv1", 32'(dv_a1 - b_a1), 32'd1);
    chk("ent_rr_a", 32'(rr_a - b_rra), 32'd1);
    chk("ent_dir_b", 32'(bus_b.direction), 32'h1F);
    chk("ent_rr_b", 32'(rr_b - b_rrb), 32'd1);
    chk("ent_dv_b", 32'(dv_b0 - b_b0), 32'd1);

    // 1D after Enter: ignored by the 1-player DUT
    snap();
    send_frame(8'h1D, 1'b0);
    chk("np1_dir_b", 32'(bus_b.direction), 32'h1F);
    chk("np1_dv_b", 32'(dv_b0 - b_b0), 32'd0);
    chk("np1_dir_a", 32'(bus_a.direction), 32'({5'b00010, 5'b11111}));

    // Timeout after 5 bits
    snap();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    cyc(TO + 50);
    chk("to_fe", 32'(fe_a - b_fea), 32'd1);
    chk("to_dv0", 32'(dv_a0 - b_a0), 32'd0);
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'h74, 1'b0);
    chk("to_right_p0", 32'(bus_a.direction[4:0]), 32'(5'b10000));
    chk("to_right_fe", 32'(fe_a - b_fea), 32'd0);

    // Reversal
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    chk("rev_up", 32'(bus_a.direction[4:0]), 32'(5'b00010));
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'h72, 1'b0);
`ifdef REVERSAL_BLOCK_EN
    chk("rev_down", 32'(bus_a.direction[4:0]), 32'(5'b00010));
    chk("rev_down_dv", 32'(dv_a0 - b_a0), 32'd0);
`else
    chk("rev_down", 32'(bus_a.direction[4:0]), 32'(5'b01000));
    chk("rev_down_dv", 32'(dv_a0 - b_a0), 32'd1);
`endif
    send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
    chk("rev_left", 32'(bus_a.direction[4:0]), 32'(5'b00100));

    // Typematic repeat
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
    chk("rep_dv0", 32'(dv_a0 - b_a0), 32'd1);
    chk("rep_p0", 32'(bus_a.direction[4:0]), 32'(5'b00100));

    // Extended break
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h74, 1'b0);
    chk("xbrk_dv0", 32'(dv_a0 - b_a0), 32'd0);
    chk("xbrk_p0", 32'(bus_a.direction[4:0]), 32'(5'b00100));

    // frame_err drops the E0 prefix: 75 becomes a player-3 key (inactive)
    snap();
    send_frame(8'hE0, 1'b0); send_frame(8'h1D, 1'b1); send_frame(8'h75, 1'b0);
    chk("pfx_fe", 32'(fe_a - b_fea), 32'd1);
    chk("pfx_dv0", 32'(dv_a0 - b_a0), 32'd0);
    chk("pfx_dv1", 32'(dv_a1 - b_a1), 32'd0);
    chk("pfx_p0", 32'(bus_a.direction[4:0]), 32'(5'b00100));

    // Reset mid-frame
    snap();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk("mrst_dir_a", 32'(bus_a.direction), 32'h0);
    chk("mrst_dir_b", 32'(bus_b.direction), 32'h0);
    cyc(TO + 50);
    chk("mrst_fe", 32'(fe_a - b_fea), 32'd0);
    chk("mrst_rr", 32'(rr_a - b_rra), 32'd0);
    send_frame(8'hE0, 1'b0); send_frame(8'h75, 1'b0);
    chk("mrst_up_p0", 32'(bus_a.direction[4:0]), 32'(5'b00010));
    chk("mrst_dv0", 32'(dv_a0 - b_a0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
